// File: rtl/axi_sram_rd_slave_if.sv
// AXI read-channel bundle (AR + R) between the interconnect and the SRAM read slave.
// The master modport is the interconnect side. The slave modport is the read engine.
interface axi_sram_rd_slave_if #(
    parameter int IDS_BITS  = 8,
    parameter int DATA_BITS = 32
);
    logic [IDS_BITS-1:0]  ARID_S;
    logic [31:0]          ARADDR_S;
    logic [3:0]           ARLEN_S;
    logic [2:0]           ARSIZE_S;
    logic [1:0]           ARBURST_S;
    logic                 ARVALID_S;
    logic                 ARREADY_S;

    logic [IDS_BITS-1:0]  RID_S;
    logic [DATA_BITS-1:0] RDATA_S;
    logic [1:0]           RRESP_S;
    logic                 RLAST_S;
    logic                 RVALID_S;
    logic                 RREADY_S;

    modport master (
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );

    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );
endinterface

// File: rtl/axi_sram_rd_slave.sv
// AXI read slave in front of a 1-cycle-latency SRAM macro.
// It handles one burst at a time, with up to 16 beats of 32-bit words.
// Each beat walks MEM -> CAP -> RESP, so a beat is returned 3 cycles after the previous handshake.
// Optional macro AXI_RD_RANGE_CHECK_EN: requests with address bits above the SRAM range
// get DECERR on every beat. For those requests the SRAM is never accessed.
module axi_sram_rd_slave #(
    parameter int MEM_ADDR_BITS = 14,
    parameter int IDS_BITS      = 8,
    parameter int DATA_BITS     = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    axi_sram_rd_slave_if.slave       bus,
    output logic                     MEM_CS,
    output logic                     MEM_OE,
    output logic [MEM_ADDR_BITS-1:0] MEM_A,
    input  logic [DATA_BITS-1:0]     MEM_DO
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        MEM  = 4'b0010,
        CAP  = 4'b0100,
        RESP = 4'b1000
    } state_t;

    state_t state;
    state_t next_state;

    logic [IDS_BITS-1:0]      id_q;
    logic [MEM_ADDR_BITS-1:0] addr_q;
    logic [3:0]               len_q;
    logic [1:0]               burst_q;
    logic [3:0]               beat_cnt;
    logic [DATA_BITS-1:0]     rdata_q;
    logic                     arready_q;
    logic                     decerr_q;

    logic ar_hs;
    logic r_hs;
    logic last_beat;
    logic addr_out_of_range;
    logic unused_bits;

    assign ar_hs     = arready_q & bus.ARVALID_S;
    assign r_hs      = (state == RESP) & bus.RREADY_S;
    assign last_beat = (beat_cnt == len_q);

`ifdef AXI_RD_RANGE_CHECK_EN
    assign addr_out_of_range = |bus.ARADDR_S[31:MEM_ADDR_BITS+2];
`else
    assign addr_out_of_range = 1'b0;
`endif

    // Word-only slave: the size and byte-lane bits carry no information for this engine.
    assign unused_bits = ^{bus.ARSIZE_S, bus.ARADDR_S[1:0], bus.ARADDR_S[31:MEM_ADDR_BITS+2]};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one SRAM access and one response per beat.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (ar_hs) next_state = MEM;
            MEM:  next_state = CAP;
            CAP:  next_state = RESP;
            RESP: if (bus.RREADY_S) next_state = last_beat ? IDLE : MEM;
            default: next_state = IDLE;
        endcase
    end

    // ARREADY is registered so that it stays low while reset is held.
    // It rises one cycle after release, and one cycle after the final R handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arready_q <= 1'b0;
        end else begin
            arready_q <= (next_state == IDLE);
        end
    end

    // Burst context: latched at the AR handshake and advanced on each non-final R handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            decerr_q <= 1'b0;
        end else if (ar_hs) begin
            id_q     <= bus.ARID_S;
            addr_q   <= bus.ARADDR_S[MEM_ADDR_BITS+1:2];
            len_q    <= bus.ARLEN_S;
            burst_q  <= bus.ARBURST_S;
            beat_cnt <= 4'd0;
            decerr_q <= addr_out_of_range;
        end else if (r_hs && !last_beat) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (burst_q != 2'b00) begin
                addr_q <= addr_q + MEM_ADDR_BITS'(1);
            end
        end
    end

    // Capture the SRAM word one cycle after the access. A flagged burst returns zeros.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (state == CAP) begin
            rdata_q <= decerr_q ? '0 : MEM_DO;
        end
    end

    // Outputs are decoded from the state and registers only. RREADY affects nothing but the state advance.
    always_comb begin
        MEM_CS        = 1'b0;
        MEM_OE        = 1'b0;
        MEM_A         = addr_q;
        bus.ARREADY_S = arready_q;
        bus.RVALID_S  = 1'b0;
        bus.RLAST_S   = 1'b0;
        bus.RRESP_S   = 2'b00;
        bus.RID_S     = id_q;
        bus.RDATA_S   = rdata_q;
        if (state == MEM && !decerr_q) begin
            MEM_CS = 1'b1;
            MEM_OE = 1'b1;
        end
        if (state == RESP) begin
            bus.RVALID_S = 1'b1;
            bus.RLAST_S  = last_beat;
            bus.RRESP_S  = decerr_q ? 2'b11 : 2'b00;
        end
    end

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Directed bench for axi_sram_rd_slave: a table of bursts checked cycle by cycle,
// plus hand-written reset and mid-burst reset sequences.
// Expectations follow AXI_RD_RANGE_CHECK_EN when it is defined.
module tb_axi_sram_rd_slave;

    localparam int MAB = 14;

    logic           clk;
    logic           rstn;
    logic           mem_cs;
    logic           mem_oe;
    logic [MAB-1:0] mem_a;
    logic [31:0]    mem_do;
    logic [31:0]    mem [0:(1<<MAB)-1];

    int tests_run;
    int tests_failed;

    axi_sram_rd_slave_if #(.IDS_BITS(8), .DATA_BITS(32)) bus ();

    axi_sram_rd_slave #(.MEM_ADDR_BITS(MAB), .IDS_BITS(8), .DATA_BITS(32)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus.slave),
        .MEM_CS (mem_cs),
        .MEM_OE (mem_oe),
        .MEM_A  (mem_a),
        .MEM_DO (mem_do)
    );

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        int          exp_word0;
        int          bp_beat;
        int          bp_cycles;
    } vec_t;

    vec_t vecs [8];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data appears one cycle after CS&OE.
    always @(posedge clk) begin
        if (mem_cs && mem_oe) mem_do <= mem[mem_a];
    end

    function automatic logic [31:0] pattern(input int i);
        return 32'h5A00_0000 ^ (i * 32'h0001_0101);
    endfunction

    function automatic logic [31:0] exp_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : pattern(i);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.ARID_S    = v.id;
        bus.ARADDR_S  = v.addr;
        bus.ARLEN_S   = v.len;
        bus.ARSIZE_S  = 3'b010;
        bus.ARBURST_S = v.burst;
        bus.ARVALID_S = 1'b1;
    endtask

    task automatic runBurst(input vec_t v);
        logic           dec;
        int             nbeats;
        int             stall;
        logic [MAB-1:0] wa;
        logic [31:0]    ed;
        logic [1:0]     er;
        dec = 1'b0;
`ifdef AXI_RD_RANGE_CHECK_EN
        dec = (v.addr[31:MAB+2] != 0);
`endif
        nbeats = int'(v.len) + 1;
        applyStimulus(v);
        checkOutput("arready_idle", 32'(bus.ARREADY_S), 32'd1);
        tick;
        bus.ARVALID_S = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wa = MAB'(v.exp_word0 + ((v.burst == 2'b00) ? 0 : b));
            ed = dec ? 32'h0 : exp_word(int'(wa));
            er = dec ? 2'b11 : 2'b00;
            checkOutput("mem_cs", 32'(mem_cs), dec ? 32'd0 : 32'd1);
            if (!dec) checkOutput("mem_a", 32'(mem_a), 32'(wa));
            checkOutput("arready_busy", 32'(bus.ARREADY_S), 32'd0);
            checkOutput("rvalid_mem", 32'(bus.RVALID_S), 32'd0);
            tick;
            checkOutput("mem_cs_cap", 32'(mem_cs), 32'd0);
            checkOutput("rvalid_cap", 32'(bus.RVALID_S), 32'd0);
            tick;
            stall = (b == v.bp_beat) ? v.bp_cycles : 0;
            bus.RREADY_S = (stall == 0);
            for (int s = 0; s <= stall; s++) begin
                if (s == stall) bus.RREADY_S = 1'b1;
                checkOutput("rvalid", 32'(bus.RVALID_S), 32'd1);
                checkOutput("rdata", bus.RDATA_S, ed);
                checkOutput("rid", 32'(bus.RID_S), 32'(v.id));
                checkOutput("rlast", 32'(bus.RLAST_S), (b == nbeats - 1) ? 32'd1 : 32'd0);
                checkOutput("rresp", 32'(bus.RRESP_S), 32'(er));
                checkOutput("mem_cs_resp", 32'(mem_cs), 32'd0);
                tick;
            end
        end
        checkOutput("arready_after", 32'(bus.ARREADY_S), 32'd1);
        checkOutput("rvalid_after", 32'(bus.RVALID_S), 32'd0);
        checkOutput("rlast_after", 32'(bus.RLAST_S), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic rv_seen;
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < (1 << MAB); i++) mem[i] = pattern(i);
        mem[4] = 32'hDEAD_BEEF;

        // Columns: id, addr, len, burst, first word, stalled beat, stall cycles.
        vecs[0] = '{8'h15, 32'h0000_0010, 4'd0,  2'b01, 4,     -1, 0};
        vecs[1] = '{8'h21, 32'h0000_0100, 4'd3,  2'b01, 64,    -1, 0};
        vecs[2] = '{8'h33, 32'h0000_0080, 4'd2,  2'b01, 32,     1, 5};
        vecs[3] = '{8'h44, 32'h0000_0040, 4'd2,  2'b00, 16,    -1, 0};
        vecs[4] = '{8'h55, 32'h0000_FFFC, 4'd1,  2'b01, 16383, -1, 0};
        vecs[5] = '{8'h66, 32'h0001_0000, 4'd1,  2'b01, 0,     -1, 0};
        vecs[6] = '{8'h77, 32'h0000_0203, 4'd1,  2'b10, 128,    0, 2};
        vecs[7] = '{8'hFF, 32'h0000_003C, 4'd15, 2'b01, 15,    -1, 0};

        rstn          = 1'b0;
        bus.ARVALID_S = 1'b1;
        bus.ARID_S    = 8'hAA;
        bus.ARADDR_S  = 32'h0;
        bus.ARLEN_S   = 4'd0;
        bus.ARSIZE_S  = 3'b010;
        bus.ARBURST_S = 2'b01;
        bus.RREADY_S  = 1'b1;
        tick;
        tick;
        checkOutput("rst_arready", 32'(bus.ARREADY_S), 32'd0);
        checkOutput("rst_rvalid", 32'(bus.RVALID_S), 32'd0);
        checkOutput("rst_rlast", 32'(bus.RLAST_S), 32'd0);
        checkOutput("rst_rdata", bus.RDATA_S, 32'd0);
        checkOutput("rst_rid", 32'(bus.RID_S), 32'd0);
        checkOutput("rst_mem_cs", 32'(mem_cs), 32'd0);
        checkOutput("rst_mem_a", 32'(mem_a), 32'd0);
        rstn = 1'b1;
        tick;
        checkOutput("rel_arready", 32'(bus.ARREADY_S), 32'd1);
        bus.ARVALID_S = 1'b0;
        checkOutput("rel_rvalid", 32'(bus.RVALID_S), 32'd0);
        tick;

        for (int i = 0; i < 8; i++) begin
            runBurst(vecs[i]);
            tick;
        end

        // Mid-burst reset: the burst is abandoned and no further beats appear.
        v = '{8'h88, 32'h0000_0020, 4'd3, 2'b01, 8, -1, 0};
        applyStimulus(v);
        tick;
        bus.ARVALID_S = 1'b0;
        tick;
        tick;
        checkOutput("mid_rvalid_pre", 32'(bus.RVALID_S), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("mid_rvalid", 32'(bus.RVALID_S), 32'd0);
        checkOutput("mid_arready", 32'(bus.ARREADY_S), 32'd0);
        checkOutput("mid_rid", 32'(bus.RID_S), 32'd0);
        checkOutput("mid_rdata", bus.RDATA_S, 32'd0);
        checkOutput("mid_mem_cs", 32'(mem_cs), 32'd0);
        tick;
        rstn = 1'b1;
        tick;
        checkOutput("mid_rel_arready", 32'(bus.ARREADY_S), 32'd1);
        rv_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.RVALID_S || mem_cs) rv_seen = 1'b1;
            tick;
        end
        checkOutput("mid_no_beats", 32'(rv_seen), 32'd0);

        runBurst(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
